// File: rtl/ofdm_symbol_framer.sv
// ofdm_symbol_framer: strips the cyclic prefix from NUM_SYMS OFDM symbols per detector trigger.
// Ports:
//   clk, reset_n (async active-low), clear (sync active-high, same effect as reset)
//   s_tdata/s_tvalid/s_tready  : raw IQ samples, I in [31:16], Q in [15:0]
//   d_tdata/d_tlast/d_tvalid/d_tready : detector phase and one-beat trigger, beat-aligned with s_*
//   o_tdata/o_tlast/o_tuser/o_eob/o_tvalid/o_tready : useful samples, symbol end, latched phase, burst end
//   busy          : framer is inside a burst
//   dropped_trig  : saturating count of triggers seen while busy
module ofdm_symbol_framer #(
   parameter int SYM_LEN  = 64,
   parameter int CP_LEN   = 16,
   parameter int NUM_SYMS = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic [31:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic [15:0] d_tdata,
   input  logic        d_tlast,
   input  logic        d_tvalid,
   output logic        d_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic [15:0] o_tuser,
   output logic        o_eob,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic        busy,
   output logic [7:0]  dropped_trig
);
   typedef enum logic [1:0] {IDLE, SKIP, EMIT} state_t;
   localparam logic [15:0] CP_LAST  = 16'(CP_LEN - 1);
   localparam logic [15:0] SYM_LAST = 16'(SYM_LEN - 1);
   localparam logic [7:0]  SYMS_LAST = 8'(NUM_SYMS - 1);
   state_t      state;
   logic [15:0] cnt;
   logic [7:0]  sym;
   logic        emit, beat;
   // Only EMIT depends on downstream; the prefix and idle samples are drained freely.
   assign emit     = state == EMIT;
   assign beat     = s_tvalid & d_tvalid & (!emit | o_tready);
   assign s_tready = beat;
   assign d_tready = beat;
   assign o_tvalid = s_tvalid & d_tvalid & emit;
   assign o_tdata  = s_tdata;
   assign o_tlast  = emit & (cnt == SYM_LAST);
   assign o_eob    = o_tlast & (sym == SYMS_LAST);
   assign busy     = state != IDLE;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         sym          <= '0;
         o_tuser      <= '0;
         dropped_trig <= '0;
      end else if (clear) begin
         state        <= IDLE;
         cnt          <= '0;
         sym          <= '0;
         o_tuser      <= '0;
         dropped_trig <= '0;
      end else if (beat) begin
         if (busy && d_tlast && dropped_trig != 8'hFF)
            dropped_trig <= dropped_trig + 8'd1;
         unique case (state)
            // The trigger beat itself is prefix sample 0.
            IDLE: if (d_tlast) begin
               o_tuser <= d_tdata;
               sym     <= '0;
               state   <= (CP_LEN == 1) ? EMIT : SKIP;
               cnt     <= (CP_LEN == 1) ? 16'd0 : 16'd1;
            end
            SKIP: if (cnt == CP_LAST) begin
               state <= EMIT;
               cnt   <= '0;
            end else cnt <= cnt + 16'd1;
            EMIT: if (o_tlast) begin
               cnt <= '0;
               if (o_eob) state <= IDLE;
               else begin
                  sym   <= sym + 8'd1;
                  state <= SKIP;
               end
            end else cnt <= cnt + 16'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// tb_ofdm_symbol_framer: directed bench for the cyclic-prefix stripping framer.
module tb_ofdm_symbol_framer;
   logic        clk = 0;
   logic        reset_n = 0;
   logic        clear = 0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 0;
   logic [15:0] d_tdata = '0;
   logic        d_tlast = 0;
   logic        d_tvalid = 0;
   logic        o_tready = 1;
   logic        s_tready, d_tready, o_tlast, o_eob, o_tvalid, busy;
   logic [31:0] o_tdata;
   logic [15:0] o_tuser;
   logic [7:0]  dropped_trig;
   logic        s2_tready, d2_tready, o2_tlast, o2_eob, o2_tvalid, busy2;
   logic [31:0] o2_tdata;
   logic [15:0] o2_tuser;
   logic [7:0]  dropped2;
   int total = 0;
   int bad = 0;
   typedef struct {logic [31:0] d; logic l; logic e; logic [15:0] u;} rec_t;
   rec_t q[$];
   rec_t q2[$];
   bit          trig[0:511];
   logic [15:0] ph[0:511];

   always #5 clk = ~clk;

   ofdm_symbol_framer #(.SYM_LEN(4), .CP_LEN(2), .NUM_SYMS(2)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .d_tdata(d_tdata), .d_tlast(d_tlast), .d_tvalid(d_tvalid), .d_tready(d_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser), .o_eob(o_eob),
      .o_tvalid(o_tvalid), .o_tready(o_tready), .busy(busy), .dropped_trig(dropped_trig));

   ofdm_symbol_framer #(.SYM_LEN(1), .CP_LEN(1), .NUM_SYMS(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s2_tready),
      .d_tdata(d_tdata), .d_tlast(d_tlast), .d_tvalid(d_tvalid), .d_tready(d2_tready),
      .o_tdata(o2_tdata), .o_tlast(o2_tlast), .o_tuser(o2_tuser), .o_eob(o2_eob),
      .o_tvalid(o2_tvalid), .o_tready(o_tready), .busy(busy2), .dropped_trig(dropped2));

   // Inputs change only just after posedge, so a negedge sample sees the transfer about to happen.
   always @(negedge clk) begin
      if (o_tvalid && o_tready) q.push_back('{o_tdata, o_tlast, o_eob, o_tuser});
      if (o2_tvalid && o_tready) q2.push_back('{o2_tdata, o2_tlast, o2_eob, o2_tuser});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      s_tvalid = 0;
      d_tvalid = 0;
      d_tlast  = 0;
      o_tready = 1;
      reset_n  = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   task automatic clr_stim();
      for (int i = 0; i < 512; i++) begin
         trig[i] = 0;
         ph[i]   = '0;
      end
   endtask

   // Present samples 0..n-1, holding each until accepted; tog flips o_tready every cycle.
   task automatic feed(input int n, input bit tog);
      bit acc;
      for (int i = 0; i < n; i++) begin
         s_tdata  = 32'(i);
         d_tdata  = ph[i];
         d_tlast  = trig[i];
         s_tvalid = 1;
         d_tvalid = 1;
         acc = 0;
         for (int k = 0; k < 8 && !acc; k++) begin
            o_tready = tog ? ~o_tready : 1'b1;
            @(negedge clk) acc = s_tready;
            @(posedge clk);
            #1;
         end
         if (!acc) begin
            total++;
            bad++;
            $error("FAIL stall sample=%0d observed=stuck expected=accepted", i);
         end
      end
      s_tvalid = 0;
      d_tvalid = 0;
      d_tlast  = 0;
   endtask

   // Two 4-sample symbols starting at sample 'first', second one 6 samples later.
   task automatic chk_burst(input int base, input int first, input logic [15:0] u);
      for (int j = 0; j < 8; j++) begin
         int d;
         d = first + j + ((j >= 4) ? 2 : 0);
         if (base + j < q.size()) begin
            chk($sformatf("data[%0d]", base + j), q[base + j].d, 32'(d));
            chk($sformatf("tlast[%0d]", base + j), 32'(q[base + j].l), 32'(j == 3 || j == 7));
            chk($sformatf("eob[%0d]", base + j), 32'(q[base + j].e), 32'(j == 7));
            chk($sformatf("tuser[%0d]", base + j), 32'(q[base + j].u), 32'(u));
         end else chk($sformatf("missing[%0d]", base + j), 32'(q.size()), 32'(base + j + 1));
      end
   endtask

   initial begin
      clr_stim();
      do_reset();
      @(negedge clk);
      chk("rst_tvalid", 32'(o_tvalid), 0);
      chk("rst_tlast", 32'(o_tlast), 0);
      chk("rst_eob", 32'(o_eob), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tuser", 32'(o_tuser), 0);
      chk("rst_drop", 32'(dropped_trig), 0);
      chk("rst_sready", 32'(s_tready), 0);
      @(posedge clk);
      #1;

      // Basic burst
      trig[3] = 1;
      ph[3]   = 16'h1234;
      q.delete();
      feed(20, 0);
      chk("basic_cnt", 32'(q.size()), 8);
      chk_burst(0, 5, 16'h1234);
      chk("basic_busy", 32'(busy), 0);
      chk("basic_tuser_hold", 32'(o_tuser), 32'h1234);

      // Backpressure
      do_reset();
      q.delete();
      feed(20, 1);
      chk("bp_cnt", 32'(q.size()), 8);
      chk_burst(0, 5, 16'h1234);

      // Trigger while busy
      do_reset();
      trig[7] = 1;
      q.delete();
      feed(20, 0);
      chk("busy_cnt", 32'(q.size()), 8);
      chk_burst(0, 5, 16'h1234);
      chk("busy_drop", 32'(dropped_trig), 1);
      do_reset();
      for (int i = 0; i < 300; i++) trig[i] = 1;
      feed(300, 0);
      chk("drop_sat", 32'(dropped_trig), 255);

      // Back-to-back bursts
      clr_stim();
      do_reset();
      trig[3]  = 1;
      ph[3]    = 16'h1234;
      trig[15] = 1;
      ph[15]   = 16'h0F0F;
      q.delete();
      feed(31, 0);
      chk("b2b_cnt", 32'(q.size()), 16);
      chk_burst(0, 5, 16'h1234);
      chk_burst(8, 17, 16'h0F0F);
      chk("b2b_drop", 32'(dropped_trig), 0);

      // Minimum CP on the 1/1/1 instance
      clr_stim();
      do_reset();
      trig[0] = 1;
      ph[0]   = 16'hABCD;
      q2.delete();
      feed(4, 0);
      chk("min_cnt", 32'(q2.size()), 1);
      if (q2.size() > 0) begin
         chk("min_data", q2[0].d, 1);
         chk("min_tlast", 32'(q2[0].l), 1);
         chk("min_eob", 32'(q2[0].e), 1);
         chk("min_tuser", 32'(q2[0].u), 32'hABCD);
      end
      chk("min_busy", 32'(busy2), 0);

      // Abort with asynchronous reset
      clr_stim();
      do_reset();
      trig[3] = 1;
      ph[3]   = 16'h1234;
      feed(6, 0);
      s_tdata  = 32'd6;
      s_tvalid = 1;
      d_tvalid = 1;
      o_tready = 1;
      #1 chk("abort_pre_valid", 32'(o_tvalid), 1);
      #1 reset_n = 0;
      #1;
      chk("abort_rst_valid", 32'(o_tvalid), 0);
      chk("abort_rst_tuser", 32'(o_tuser), 0);
      chk("abort_rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1 reset_n = 1;
      s_tvalid = 0;
      d_tvalid = 0;

      // Abort with synchronous clear
      feed(6, 0);
      s_tdata  = 32'd6;
      s_tvalid = 1;
      d_tvalid = 1;
      o_tready = 1;
      clear    = 1;
      #2;
      chk("abort_clr_pre", 32'(o_tvalid), 1);
      @(posedge clk);
      #1;
      chk("abort_clr_valid", 32'(o_tvalid), 0);
      chk("abort_clr_tuser", 32'(o_tuser), 0);
      chk("abort_clr_busy", 32'(busy), 0);
      clear    = 0;
      s_tvalid = 0;
      d_tvalid = 0;

      // Fresh burst after abort
      ph[3] = 16'h5555;
      q.delete();
      feed(20, 0);
      chk("fresh_cnt", 32'(q.size()), 8);
      chk_burst(0, 5, 16'h5555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
